// File: rtl/tanh_backprop_unit_pkg.sv
// Shared fixed-point constants for the tanh activation and its backward pass.
package tanh_backprop_unit_pkg;

  localparam int unsigned ACT_DATA_WIDTH  = 16;
  localparam int unsigned ACT_FRACT_WIDTH = 8;

  typedef logic signed [ACT_DATA_WIDTH-1:0] act_data_t;

  localparam act_data_t ACT_ONE      = act_data_t'(1 << ACT_FRACT_WIDTH);
  localparam act_data_t ACT_CLAMP_HI = ACT_ONE;
  localparam act_data_t ACT_CLAMP_LO = -ACT_ONE;

endpackage

// File: rtl/fxp_mul_shift.sv
// Signed-by-unsigned fixed-point multiply, arithmetic shift right by FRACT_WIDTH, truncated.
module fxp_mul_shift #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FRACT_WIDTH = 8
) (
  input  logic signed [DATA_WIDTH-1:0] i_a,
  input  logic        [DATA_WIDTH-1:0] i_b,
  output logic        [DATA_WIDTH-1:0] o_p_c
);

  localparam int unsigned PW = 2 * DATA_WIDTH + 1;

  logic signed [PW-1:0] w_prod;

  // Zero-extend the unsigned operand so the product stays signed.
  assign w_prod = PW'(i_a) * PW'($signed({1'b0, i_b}));
  assign o_p_c  = DATA_WIDTH'(w_prod >>> FRACT_WIDTH);

endmodule

// File: rtl/tanh_backprop_unit.sv
// Backward pass of tanh: g_out = g * (1 - y^2) through a clamp / derivative / scale pipeline
// with a single global stall driven by the output handshake.
module tanh_backprop_unit
  import tanh_backprop_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = ACT_DATA_WIDTH,
  parameter int unsigned FRACT_WIDTH = ACT_FRACT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] y_in,
  input  logic [DATA_WIDTH-1:0] g_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] g_out,
  output logic                  y_clamped
);

  localparam logic signed [DATA_WIDTH-1:0] ONE_S     = DATA_WIDTH'(1 << FRACT_WIDTH);
  localparam logic signed [DATA_WIDTH-1:0] NEG_ONE_S = -ONE_S;

  logic                         w_advance;
  logic signed [DATA_WIDTH-1:0] w_y_sin;
  logic                         w_hi;
  logic                         w_lo;
  logic signed [DATA_WIDTH-1:0] w_y_clamp;
  logic signed [DATA_WIDTH-1:0] w_y_abs;
  logic        [DATA_WIDTH-1:0] w_sq_shr;
  logic        [DATA_WIDTH-1:0] w_d;
  logic        [DATA_WIDTH-1:0] w_g_scaled;

  logic                         r_v1;
  logic signed [DATA_WIDTH-1:0] r_y1;
  logic        [DATA_WIDTH-1:0] r_g1;
  logic                         r_c1;
  logic                         r_v2;
  logic        [DATA_WIDTH-1:0] r_d2;
  logic        [DATA_WIDTH-1:0] r_g2;
  logic                         r_c2;
  logic                         r_out_valid;
  logic        [DATA_WIDTH-1:0] r_g_out;
  logic                         r_y_clamped;

  assign w_advance = ~r_out_valid | out_ready;
  assign in_ready  = w_advance;

  // Stage 1: clamp y into [-ONE, +ONE].
  assign w_y_sin   = $signed(y_in);
  assign w_hi      = w_y_sin > ONE_S;
  assign w_lo      = w_y_sin < NEG_ONE_S;
  assign w_y_clamp = w_hi ? ONE_S : (w_lo ? NEG_ONE_S : w_y_sin);

  // Stage 2: d = ONE - y^2; squaring |y| keeps the unsigned operand in range.
  assign w_y_abs = r_y1[DATA_WIDTH-1] ? -r_y1 : r_y1;

  fxp_mul_shift #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRACT_WIDTH(FRACT_WIDTH)
  ) u_square (
    .i_a  (w_y_abs),
    .i_b  (w_y_abs),
    .o_p_c(w_sq_shr)
  );

  assign w_d = DATA_WIDTH'(ONE_S) - w_sq_shr;

  // Stage 3: scale the gradient by the derivative.
  fxp_mul_shift #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRACT_WIDTH(FRACT_WIDTH)
  ) u_scale (
    .i_a  ($signed(r_g2)),
    .i_b  (r_d2),
    .o_p_c(w_g_scaled)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1        <= 1'b0;
      r_y1        <= '0;
      r_g1        <= '0;
      r_c1        <= 1'b0;
      r_v2        <= 1'b0;
      r_d2        <= '0;
      r_g2        <= '0;
      r_c2        <= 1'b0;
      r_out_valid <= 1'b0;
      r_g_out     <= '0;
      r_y_clamped <= 1'b0;
    end else if (w_advance) begin
      r_v1        <= in_valid;
      r_y1        <= w_y_clamp;
      r_g1        <= g_in;
      r_c1        <= w_hi | w_lo;
      r_v2        <= r_v1;
      r_d2        <= w_d;
      r_g2        <= r_g1;
      r_c2        <= r_c1;
      r_out_valid <= r_v2;
      // Output data only moves for real results so it stays meaningful across bubbles.
      if (r_v2) begin
        r_g_out     <= w_g_scaled;
        r_y_clamped <= r_c2;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign g_out     = r_g_out;
  assign y_clamped = r_y_clamped;

endmodule

// File: doc/tanh_backprop_unit.md
Name: tanh_backprop_unit

Overview:
- Backward-pass counterpart of the tanh activation: takes stored forward tanh outputs Y and upstream gradients G, and produces G_out = G * (1 - Y^2).
- Streaming 3-stage pipeline with valid/ready handshake. Sits between the loss/gradient path and the weight-update logic of the denoise network.
- Uses the same signed fixed-point format as the forward activation.

Parameters:
- DATA_WIDTH, 16, total signed width of Y, G and G_out.
- FRACT_WIDTH, 8, fractional bits; ONE = 1 << FRACT_WIDTH (0x0100).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  Y/G pair present.
- in_ready  out  1  unit accepts the pair this cycle.
- y_in  in  DATA_WIDTH  signed forward tanh output.
- g_in  in  DATA_WIDTH  signed upstream gradient.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- g_out  out  DATA_WIDTH  signed gradient G*(1-Y^2).
- y_clamped  out  1  y_in of this result was outside [-ONE, +ONE] and was clamped.

Behaviour:
- Reset: all stage valid bits = 0, out_valid = 0, g_out = 0, y_clamped = 0. in_ready = 1 from the first cycle after reset.
- Pipeline control: global advance = ~out_valid | out_ready; in_ready = advance.
  - When advance = 0, all stages hold, including data and valid bits.
  - A transfer occurs on in_valid & in_ready and on out_valid & out_ready.
- Latency: 3 cycles from input accept to out_valid with no stalls. Throughput is 1 result per cycle.
- Stage 1 (clamp):
  - y_s1 = y_in if -ONE <= y_in <= ONE.
  - Otherwise y_s1 = +ONE (y_in > ONE) or -ONE (y_in < -ONE), and the clamp flag is set.
  - g_s1 = g_in. The valid bit is set from in_valid.
- Stage 2 (derivative):
  - sq = y_s1 * y_s1, a 2*DATA_WIDTH unsigned product.
  - d_s2 = ONE - (sq >> FRACT_WIDTH), so d_s2 lies in [0, ONE]. It is held as a DATA_WIDTH-bit unsigned value; no underflow is possible after the clamp.
  - g and the clamp flag pass through.
- Stage 3 (scale):
  - p = signed(g_s2) * {0, d_s2}, a 2*DATA_WIDTH signed product.
  - g_out = p >>> FRACT_WIDTH, truncated to DATA_WIDTH (arithmetic shift, floor rounding).
  - |g_out| <= |g| always holds, so no saturation logic is needed.
- Output registers: g_out and y_clamped change only when advance = 1 and stage 3 loads. They hold stable while out_valid & ~out_ready.
- Bubbles: invalid slots propagate as valid = 0. Data registers in bubble slots may load freely, but the output register loads only for valid data.
- Simultaneous events:
  - Accept and emit in the same cycle are allowed when out_ready = 1.
  - in_valid with in_ready = 0 is not consumed; the source must hold its data.
- Reset mid-stream: all in-flight results are discarded and out_valid drops in the cycle after reset is asserted. No partial result is emitted.
- Arithmetic examples:
  - y = 0 gives d = 0x0100.
  - y = +/-0x0080 gives d = 0x00C0.
  - y = +/-0x0100 gives d = 0.

Decomposition:
- Shared package (activation-function constants):
  - DATA_WIDTH / FRACT_WIDTH defaults.
  - ONE = 16'h0100.
  - Clamp bounds +/-ONE.
  - A signed fixed-point data typedef. Forward tanh and this unit both use these.
- One sub-module: fxp_mul_shift, a signed-by-unsigned multiply followed by an arithmetic right shift by FRACT_WIDTH.
  - Instantiated once in stage 3.
  - Stage 2's square may reuse it with the operand forced non-negative.

Test Plan:
- y_in = 0x0000, g_in = 0x0100, out_ready = 1 -> g_out = 0x0100, y_clamped = 0, out_valid exactly 3 cycles after accept.
- y_in = 0x0080, g_in = 0x0100 -> g_out = 0x00C0. Also y_in = 0xFF80 (-0.5), g_in = 0xFE00 (-2.0) -> g_out = 0xFE80 (-1.5).
- y_in = 0x0100 with g_in = 0x7FFF -> g_out = 0x0000. Also y_in = 0x0180, g_in = 0x0100 -> g_out = 0x0000, y_clamped = 1.
- Back-to-back stream of 8 pairs with out_ready = 0 on cycles 4-6:
  - in_ready = 0 during the stall.
  - g_out holds stable.
  - All 8 results are emitted in order with no loss or duplication.
- Assert reset for 1 cycle with 3 results in flight -> out_valid = 0 and g_out = 0 next cycle, in_ready = 1. A following single pair produces exactly one result.
- Random y_in in [-0x0200, 0x0200] and random g_in against a golden model computing floor(g * (ONE - floor(clamp(y)^2 / ONE)) / ONE) -> bit-exact match on 10k samples under random out_ready.
